// File: rtl/pred_regfile_sb.sv
// pred_regfile_sb
// Decode-stage register file with a per-register in-flight write scoreboard.
//   - NREGS x WIDTH storage, NRD asynchronous read ports, R0 hard-wired to 0.
//   - Writes to R0 and to PROT_REG are dropped, but still retire a pending count.
//   - count[r] tracks issued-but-not-retired writes (issue +1, wb -1, cncl -1).
//   - Optional feature macro: WRITE_BYPASS_EN (same-cycle writeback forwarding
//     onto read data and early busy release). Undefined by default.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rd_addr/rd_data   packed read ports, port i at [i*AW +: AW] / [i*WIDTH +: WIDTH]
//   rd_busy           port i register has pending writes
//   rd_zero           predicate-false flag: address nonzero and data zero
//   iss_valid/iss_dest/iss_ready   decode marks a destination pending
//   wb_valid/wb_dest/wb_data       writeback write (also retires one pending)
//   cncl_valid/cncl_dest           squashed write, retires one pending
//   sb_err            sticky scoreboard underflow
module pred_regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 3,
  parameter int PROT_REG = 30,
  parameter int PEND_MAX = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0]          rd_data,
  output logic [NRD-1:0]                rd_busy,
  output logic [NRD-1:0]                rd_zero,
  input  logic                          iss_valid,
  input  logic [$clog2(NREGS)-1:0]      iss_dest,
  output logic                          iss_ready,
  input  logic                          wb_valid,
  input  logic [$clog2(NREGS)-1:0]      wb_dest,
  input  logic [WIDTH-1:0]              wb_data,
  input  logic                          cncl_valid,
  input  logic [$clog2(NREGS)-1:0]      cncl_dest,
  output logic                          sb_err
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(PEND_MAX + 1);
  localparam logic [AW-1:0] PROT_ADDR = AW'(PROT_REG);
  localparam logic [CW-1:0] PEND_FULL = CW'(PEND_MAX);

  logic [WIDTH-1:0] regs_r      [NREGS];
  logic [CW-1:0]    count_r     [NREGS];
  logic [CW-1:0]    count_nxt_s [NREGS];
  logic [CW:0]      up_s        [NREGS];
  logic [CW:0]      dn_s        [NREGS];
  logic [NREGS-1:0] uflow_s;
  logic             sb_err_r;
  logic             iss_acc_s;
  logic             wb_write_s;
  logic [AW-1:0]    ra_s        [NRD];
  logic [WIDTH-1:0] rdata_s     [NRD];

  // Issue acceptance looks only at the current count, never at a same-cycle wb.
  always_comb begin
    iss_ready  = 1'b1;
    if (iss_valid && (iss_dest != {AW{1'b0}}) && (count_r[iss_dest] == PEND_FULL)) begin
      iss_ready = 1'b0;
    end else begin
      iss_ready = 1'b1;
    end
    iss_acc_s  = iss_valid && iss_ready;
    wb_write_s = wb_valid && (wb_dest != {AW{1'b0}}) && (wb_dest != PROT_ADDR);
  end

  // Next pending count per register; net change may be -2..+1, clamped at zero.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      up_s[r] = {1'b0, count_r[r]} + (CW+1)'(iss_acc_s && (iss_dest == AW'(r)));
      dn_s[r] = (CW+1)'(wb_valid && (wb_dest == AW'(r)))
              + (CW+1)'(cncl_valid && (cncl_dest == AW'(r)));
      if (r == 0) begin
        count_nxt_s[r] = {CW{1'b0}};
        uflow_s[r]     = 1'b0;
      end else if (up_s[r] < dn_s[r]) begin
        count_nxt_s[r] = {CW{1'b0}};
        uflow_s[r]     = 1'b1;
      end else begin
        count_nxt_s[r] = CW'(up_s[r] - dn_s[r]);
        uflow_s[r]     = 1'b0;
      end
    end
  end

  // Storage, scoreboard counters and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r]  <= {WIDTH{1'b0}};
        count_r[r] <= {CW{1'b0}};
      end
      sb_err_r <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        count_r[r] <= count_nxt_s[r];
      end
      if (wb_write_s) begin
        regs_r[wb_dest] <= wb_data;
      end else begin
        regs_r[wb_dest] <= regs_r[wb_dest];
      end
      if (|uflow_s) begin
        sb_err_r <= 1'b1;
      end else begin
        sb_err_r <= sb_err_r;
      end
    end
  end

  assign sb_err = sb_err_r;

  // Read ports: data, busy and predicate-zero flag per port.
  always_comb begin
    rd_data = {(NRD*WIDTH){1'b0}};
    rd_busy = {NRD{1'b0}};
    rd_zero = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      ra_s[i] = rd_addr[i*AW +: AW];
`ifdef WRITE_BYPASS_EN
      if (ra_s[i] == {AW{1'b0}}) begin
        rdata_s[i] = {WIDTH{1'b0}};
      end else if (wb_write_s && (wb_dest == ra_s[i])) begin
        rdata_s[i] = wb_data;
      end else begin
        rdata_s[i] = regs_r[ra_s[i]];
      end
      // A retiring wb (and a same-cycle cancel) releases busy early; a
      // protected-register wb still retires, so protection is not checked here.
      if (wb_valid && (wb_dest == ra_s[i]) && (ra_s[i] != {AW{1'b0}})) begin
        rd_busy[i] = {1'b0, count_r[ra_s[i]]} >
                     ((CW+1)'(1) + (CW+1)'(cncl_valid && (cncl_dest == ra_s[i])));
      end else begin
        rd_busy[i] = (count_r[ra_s[i]] != {CW{1'b0}});
      end
`else
      if (ra_s[i] == {AW{1'b0}}) begin
        rdata_s[i] = {WIDTH{1'b0}};
      end else begin
        rdata_s[i] = regs_r[ra_s[i]];
      end
      rd_busy[i] = (count_r[ra_s[i]] != {CW{1'b0}});
`endif
      rd_data[i*WIDTH +: WIDTH] = rdata_s[i];
      rd_zero[i] = (ra_s[i] != {AW{1'b0}}) && (rdata_s[i] == {WIDTH{1'b0}});
    end
  end

endmodule

// File: tb/tb_pred_regfile_sb.sv
// Directed testbench for pred_regfile_sb with an abstract behavioural model.
module tb_pred_regfile_sb;

  localparam bit BYP =
`ifdef WRITE_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic [2:0]  rd_zero;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        cncl_valid;
  logic [4:0]  cncl_dest;
  logic        sb_err;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  logic [31:0] mem [32];
  int          cnt [32];
  bit          merr;

  pred_regfile_sb dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_zero(rd_zero),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .cncl_valid(cncl_valid), .cncl_dest(cncl_dest), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    bit acc;
    int n;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        mem[r] = 32'h0;
        cnt[r] = 0;
      end
      merr = 1'b0;
    end else begin
      acc = iss_valid && (iss_dest != 5'd0) && (cnt[iss_dest] != 3);
      if (wb_valid && wb_dest != 5'd0 && wb_dest != 5'd30) mem[wb_dest] = wb_data;
      for (int r = 1; r < 32; r++) begin
        n = cnt[r];
        if (acc && iss_dest == r) n = n + 1;
        if (wb_valid && wb_dest == r) n = n - 1;
        if (cncl_valid && cncl_dest == r) n = n - 1;
        if (n < 0) begin
          n = 0;
          merr = 1'b1;
        end
        cnt[r] = n;
      end
    end
    check_en = 1'b1;
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [95:0] ed;
    logic [2:0]  eb;
    logic [2:0]  ez;
    logic        er;
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        a = rd_addr[i*5 +: 5];
        d = (a == 5'd0) ? 32'h0 : mem[a];
        c = cnt[a];
        if (BYP && wb_valid && wb_dest == a && a != 5'd0) begin
          if (a != 5'd30) d = wb_data;
          c = c - 1 - ((cncl_valid && cncl_dest == a) ? 1 : 0);
        end
        ed[i*32 +: 32] = d;
        eb[i] = (c > 0);
        ez[i] = (a != 5'd0) && (d == 32'h0);
      end
      er = !(iss_valid && iss_dest != 5'd0 && cnt[iss_dest] == 3);
      chk("cyc_rd_data", rd_data, ed);
      chk("cyc_rd_busy", rd_busy, eb);
      chk("cyc_rd_zero", rd_zero, ez);
      chk("cyc_iss_ready", iss_ready, er);
      chk("cyc_sb_err", sb_err, merr);
    end
  end

  initial begin
    reset = 1'b1; rd_addr = 15'd0;
    iss_valid = 1'b0; iss_dest = 5'd0;
    wb_valid = 1'b0; wb_dest = 5'd0; wb_data = 32'h0;
    cncl_valid = 1'b0; cncl_dest = 5'd0;
    tick(); tick();
    reset = 1'b0;
    rd_addr = {5'd30, 5'd0, 5'd5};
    #1;
    chk("rst_rd_data", rd_data, 96'h0);
    chk("rst_rd_zero", rd_zero, 3'b101);
    chk("rst_rd_busy", rd_busy, 3'b000);
    chk("rst_iss_ready", iss_ready, 1'b1);
    chk("rst_sb_err", sb_err, 1'b0);

    // Mark R7 and R30 pending, then write back R7, R30 (protected), R0.
    iss_valid = 1'b1; iss_dest = 5'd7; tick();
    iss_dest = 5'd30; tick();
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_dest = 5'd7; wb_data = 32'hDEADBEEF; tick();
    wb_dest = 5'd30; wb_data = 32'h12345678; rd_addr = {5'd30, 5'd0, 5'd7};
    #1;
    chk("r7_read", rd_data[31:0], 32'hDEADBEEF);
    tick();
    wb_dest = 5'd0; wb_data = 32'hFFFFFFFF; tick();
    wb_valid = 1'b0;
    #1;
    chk("r30_protected", rd_data[95:64], 32'h0);
    chk("r0_reads_zero", rd_data[63:32], 32'h0);
    chk("r30_zero_flag", rd_zero, 3'b100);
    chk("wb_retire_no_err", sb_err, 1'b0);

    // Fill R4 to the pending limit.
    iss_valid = 1'b1; iss_dest = 5'd4; tick(); tick(); tick();
    #1;
    chk("r4_full_ready", iss_ready, 1'b0);
    wb_valid = 1'b1; wb_dest = 5'd4; wb_data = 32'h44;
    #1;
    chk("r4_full_wb_ready", iss_ready, 1'b0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("r4_after_wb_ready", iss_ready, 1'b1);
    tick();
    iss_valid = 1'b0; rd_addr = {5'd0, 5'd0, 5'd4};
    #1;
    chk("r4_busy", rd_busy, 3'b001);

    // R9: count 2, then issue+wb+cncl in one cycle, then final wb of zero.
    iss_valid = 1'b1; iss_dest = 5'd9; tick(); tick();
    wb_valid = 1'b1; wb_dest = 5'd9; wb_data = 32'h1234;
    cncl_valid = 1'b1; cncl_dest = 5'd9; rd_addr = {5'd0, 5'd0, 5'd9};
    tick();
    iss_valid = 1'b0; cncl_valid = 1'b0; wb_data = 32'h0;
    #1;
    chk("r9_last_wb_busy", rd_busy[0], BYP ? 1'b0 : 1'b1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("r9_busy_cleared", rd_busy[0], 1'b0);
    chk("r9_zero_flag", rd_zero[0], 1'b1);
    chk("r9_data", rd_data[31:0], 32'h0);

    // Underflow on R12.
    chk("pre_uflow_err", sb_err, 1'b0);
    cncl_valid = 1'b1; cncl_dest = 5'd12; tick();
    cncl_valid = 1'b0; rd_addr = {5'd0, 5'd0, 5'd12};
    #1;
    chk("uflow_err", sb_err, 1'b1);
    tick(); tick();
    #1;
    chk("uflow_err_sticky", sb_err, 1'b1);
    chk("r12_not_busy", rd_busy[0], 1'b0);

    // Same-cycle forwarding of a write to R3 on port 1.
    iss_valid = 1'b1; iss_dest = 5'd3; tick();
    iss_valid = 1'b0; rd_addr = {5'd0, 5'd3, 5'd0};
    wb_valid = 1'b1; wb_dest = 5'd3; wb_data = 32'h55;
    #1;
    chk("r3_same_cycle", rd_data[63:32], BYP ? 32'h55 : 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("r3_after_edge", rd_data[63:32], 32'h55);

    // Reset wins over simultaneous activity.
    reset = 1'b1; iss_valid = 1'b1; iss_dest = 5'd5;
    wb_valid = 1'b1; wb_dest = 5'd6; wb_data = 32'hA5A5A5A5;
    cncl_valid = 1'b1; cncl_dest = 5'd13;
    tick();
    reset = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0; cncl_valid = 1'b0;
    rd_addr = {5'd5, 5'd6, 5'd7};
    #1;
    chk("rst2_sb_err", sb_err, 1'b0);
    chk("rst2_rd_data", rd_data, 96'h0);
    chk("rst2_rd_busy", rd_busy, 3'b000);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
